map_tile_arbiter: RTL and testbench



---
 rtl/map_pkg.sv | 29 ++
 rtl/map_tile_arbiter_if.sv | 27 ++
 rtl/rr_arbiter.sv | 22 ++
 rtl/map_tile_arbiter.sv | 121 ++++++++++++
 tb/tb_map_tile_arbiter.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/map_pkg.sv
// rtl/map_pkg.sv - shared map geometry, tile types and arbiter state encoding
package map_pkg;

    localparam int MAP_COLS = 40;
    localparam int MAP_ROWS = 30;
    localparam int TILE_W   = 4;
    localparam int ROW_W    = 160;

    typedef logic [3:0] tile_t;
    typedef logic [5:0] col_t;
    typedef logic [4:0] row_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } arb_state_e;

    function automatic logic [2:0] onehot_to_idx(input logic [7:0] oh);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (oh[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/map_tile_arbiter_if.sv
// rtl/map_tile_arbiter_if.sv - requester and map RAM port-B signals of the tile arbiter
interface map_tile_arbiter_if #(parameter int NUM_REQ = 3);

    logic [NUM_REQ-1:0]   req;
    logic [NUM_REQ*6-1:0] req_x;
    logic [NUM_REQ*5-1:0] req_y;
    logic [NUM_REQ*4-1:0] req_code;
    logic [NUM_REQ-1:0]   done;
    logic                 err;
    logic [3:0]           prev_code;
    logic                 busy;
    logic [4:0]           wraddr;
    logic                 wren;
    logic [159:0]         wrdata;
    logic [159:0]         redata;

    modport slave (
        input  req, req_x, req_y, req_code, redata,
        output done, err, prev_code, busy, wraddr, wren, wrdata
    );

    modport master (
        output req, req_x, req_y, req_code, redata,
        input  done, err, prev_code, busy, wraddr, wren, wrdata
    );

endinterface

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin grant, first set request above the pointer
module rr_arbiter #(
    parameter int N = 3
) (
    input  logic [N-1:0] i_req,
    input  logic [2:0]   i_ptr,
    output logic [N-1:0] o_gnt,
    output logic         o_valid
);

    always_comb begin
        o_gnt   = '0;
        o_valid = 1'b0;
        for (int k = 1; k <= N; k++) begin
            if (!o_valid && i_req[(int'(i_ptr) + k) % N]) begin
                o_gnt[(int'(i_ptr) + k) % N] = 1'b1;
                o_valid                      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/map_tile_arbiter.sv
// rtl/map_tile_arbiter.sv - round-robin read-modify-write of one map tile; MAP_ARB_SKIP_SAME_EN suppresses no-op writes
module map_tile_arbiter
    import map_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int RD_LAT  = 1
) (
    input  logic                 CLOCK_50,
    input  logic                 reset,
    map_tile_arbiter_if.slave    bus
);

    localparam logic [1:0] S_IDLE  = 2'(ST_IDLE);
    localparam logic [1:0] S_READ  = 2'(ST_READ);
    localparam logic [1:0] S_WRITE = 2'(ST_WRITE);
    localparam logic [1:0] S_DONE  = 2'(ST_DONE);

    logic [1:0] r_state;
    logic [2:0] r_ptr;
    logic [2:0] r_gidx;
    col_t       r_x;
    row_t       r_y;
    tile_t      r_code;
    tile_t      r_prev;
    logic       r_err;
    logic [3:0] r_cnt;

    logic [NUM_REQ-1:0] w_gnt;
    logic               w_gvalid;
    logic [2:0]         w_gidx;
    col_t               w_sel_x;
    row_t               w_sel_y;
    tile_t              w_sel_code;
    logic [7:0]         w_lsb;
    tile_t              w_old;
    logic [ROW_W-1:0]   w_row;
    logic               w_wr_en;

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .i_req   (bus.req),
        .i_ptr   (r_ptr),
        .o_gnt   (w_gnt),
        .o_valid (w_gvalid)
    );

    always_comb begin
        w_gidx     = onehot_to_idx(8'(w_gnt));
        w_sel_x    = bus.req_x[int'(w_gidx)*6 +: 6];
        w_sel_y    = bus.req_y[int'(w_gidx)*5 +: 5];
        w_sel_code = bus.req_code[int'(w_gidx)*4 +: 4];
    end

    // Column 0 is the MSB nibble of the row.
    always_comb begin
        w_lsb = 8'(ROW_W - TILE_W) - {r_x, 2'b00};
        w_old = bus.redata[w_lsb +: TILE_W];
        w_row = bus.redata;
        w_row[w_lsb +: TILE_W] = r_code;
`ifdef MAP_ARB_SKIP_SAME_EN
        w_wr_en = (w_old != r_code);
`else
        w_wr_en = 1'b1;
`endif
    end

    assign bus.busy      = (r_state != S_IDLE);
    assign bus.wraddr    = r_y;
    assign bus.wren      = (r_state == S_WRITE) && w_wr_en;
    assign bus.wrdata    = (r_state == S_WRITE) ? w_row : '0;
    assign bus.done      = (r_state == S_DONE) ? (NUM_REQ'(1) << r_gidx) : '0;
    assign bus.err       = (r_state == S_DONE) && r_err;
    assign bus.prev_code = (r_state == S_DONE) ? r_prev : 4'h0;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_ptr   <= 3'(NUM_REQ - 1);
            r_gidx  <= 3'd0;
            r_x     <= '0;
            r_y     <= '0;
            r_code  <= '0;
            r_prev  <= '0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_gvalid) begin
                        r_gidx <= w_gidx;
                        r_x    <= w_sel_x;
                        r_y    <= w_sel_y;
                        r_code <= w_sel_code;
                        r_prev <= '0;
                        r_cnt  <= '0;
                        if (w_sel_x >= col_t'(MAP_COLS) || w_sel_y >= row_t'(MAP_ROWS)) begin
                            r_err   <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_err   <= 1'b0;
                            r_state <= S_READ;
                        end
                    end
                end
                S_READ: begin
                    if (r_cnt == 4'(RD_LAT - 1)) r_state <= S_WRITE;
                    else                         r_cnt   <= r_cnt + 4'd1;
                end
                S_WRITE: begin
                    r_prev  <= w_old;
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    r_ptr   <= r_gidx;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_map_tile_arbiter.sv
// tb/tb_map_tile_arbiter.sv - directed vector bench for map_tile_arbiter with a port-B RAM model
module tb_map_tile_arbiter;

    localparam int RD_LAT = 1;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    map_tile_arbiter_if #(.NUM_REQ(3)) bus();

    map_tile_arbiter #(.NUM_REQ(3), .RD_LAT(RD_LAT)) dut (
        .CLOCK_50 (clk),
        .reset    (reset),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [159:0] mem [0:31];
    logic [159:0] rd_q;
    logic         pre_en;
    logic [4:0]   pre_addr;
    logic [159:0] pre_row;

    always @(posedge clk) begin
        if (pre_en)        mem[pre_addr]   <= pre_row;
        else if (bus.wren) mem[bus.wraddr] <= bus.wrdata;
        rd_q <= mem[bus.wraddr];
    end
    assign bus.redata = rd_q;

    typedef struct {
        int           idx;
        int           x;
        int           y;
        logic [3:0]   code;
        logic [3:0]   fill;
        logic         exp_err;
        logic [3:0]   exp_prev;
        int           exp_wren;
        logic [159:0] exp_row;
    } vec_t;

    vec_t vecs [7];

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic preload(input int addr, input logic [159:0] row);
        pre_en   = 1'b1;
        pre_addr = 5'(addr);
        pre_row  = row;
        step();
        pre_en   = 1'b0;
    endtask

    task automatic wait_done(output int idx, output int cyc);
        idx = -1;
        cyc = 0;
        for (int c = 1; c <= 20; c++) begin
            step();
            if (bus.done != 3'b000) begin
                cyc = c;
                for (int i = 0; i < 3; i++) if (bus.done[i]) idx = i;
                break;
            end
        end
    endtask

    task automatic run_vec(input vec_t v);
        int           done_cyc, wren_cnt, wren_cyc;
        logic [2:0]   done_v;
        logic         err_v, busy1;
        logic [3:0]   prev_v;
        logic [4:0]   waddr;
        logic [159:0] wdata;
        done_cyc = -1; wren_cnt = 0; wren_cyc = -1;
        done_v = '0; err_v = 1'b0; prev_v = '0; busy1 = 1'b0; waddr = '0; wdata = '0;
        if (v.y < 30) preload(v.y, {40{v.fill}});
        bus.req_x[6*v.idx +: 6]    = 6'(v.x);
        bus.req_y[5*v.idx +: 5]    = 5'(v.y);
        bus.req_code[4*v.idx +: 4] = v.code;
        bus.req[v.idx]             = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            step();
            if (c == 1) busy1 = bus.busy;
            if (bus.wren) begin
                wren_cnt++;
                wren_cyc = c;
                waddr    = bus.wraddr;
                wdata    = bus.wrdata;
            end
            if (bus.done != 3'b000) begin
                done_cyc = c;
                done_v   = bus.done;
                err_v    = bus.err;
                prev_v   = bus.prev_code;
                break;
            end
        end
        bus.req[v.idx] = 1'b0;
        step();
        chk("done_cycle", 160'(done_cyc), 160'(v.exp_err ? 1 : RD_LAT + 2));
        chk("done_vec", 160'(done_v), 160'(3'b001 << v.idx));
        chk("err", 160'(err_v), 160'(v.exp_err));
        chk("prev_code", 160'(prev_v), 160'(v.exp_prev));
        chk("busy_c1", 160'(busy1), 160'(1));
        chk("wren_count", 160'(wren_cnt), 160'(v.exp_wren));
        if (v.exp_wren != 0) begin
            chk("wren_cycle", 160'(wren_cyc), 160'(RD_LAT + 1));
            chk("wraddr", 160'(waddr), 160'(v.y));
            chk("wrdata", wdata, v.exp_row);
        end
        if (!v.exp_err) chk("ram_row", mem[v.y], v.exp_row);
    endtask

    initial begin
        int         idx, cyc;
        int         order [6];
        logic [159:0] exp_same;
        total = 0; bad = 0;
        reset = 1'b1; pre_en = 1'b0; pre_addr = '0; pre_row = '0;
        bus.req = '0; bus.req_x = '0; bus.req_y = '0; bus.req_code = '0;

        vecs[0] = '{0, 0, 3, 4'h5, 4'hA, 1'b0, 4'hA, 1, {4'h5, {39{4'hA}}}};
        vecs[1] = '{1, 39, 29, 4'h1, 4'h0, 1'b0, 4'h0, 1, 160'h1};
        vecs[2] = '{2, 1, 5, 4'h1, 4'h0, 1'b0, 4'h0, 1, {4'h0, 4'h1, {38{4'h0}}}};
        vecs[3] = '{0, 40, 0, 4'h7, 4'h0, 1'b1, 4'h0, 0, 160'h0};
        vecs[4] = '{1, 0, 30, 4'h7, 4'h0, 1'b1, 4'h0, 0, 160'h0};
        vecs[5] = '{2, 20, 10, 4'h3, 4'hF, 1'b0, 4'hF, 1, {{20{4'hF}}, 4'h3, {19{4'hF}}}};
`ifdef MAP_ARB_SKIP_SAME_EN
        vecs[6] = '{0, 7, 2, 4'hA, 4'hA, 1'b0, 4'hA, 0, {40{4'hA}}};
`else
        vecs[6] = '{0, 7, 2, 4'hA, 4'hA, 1'b0, 4'hA, 1, {40{4'hA}}};
`endif

        repeat (3) step();
        chk("rst_busy", 160'(bus.busy), 160'(0));
        chk("rst_wren", 160'(bus.wren), 160'(0));
        chk("rst_done", 160'(bus.done), 160'(0));
        chk("rst_err", 160'(bus.err), 160'(0));
        chk("rst_prev", 160'(bus.prev_code), 160'(0));
        chk("rst_wraddr", 160'(bus.wraddr), 160'(0));
        chk("rst_wrdata", bus.wrdata, 160'h0);
        reset = 1'b0;
        step();

        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // contention: all three held, each re-raised one cycle after its IDLE slot
        reset = 1'b1; step(); reset = 1'b0;
        bus.req_x = {6'd4, 6'd3, 6'd2};
        bus.req_y = {5'd4, 5'd2, 5'd1};
        bus.req_code = {4'h3, 4'h2, 4'h1};
        bus.req = 3'b111;
        for (int t = 0; t < 6; t++) begin
            wait_done(idx, cyc);
            order[t] = idx;
            if (idx >= 0) begin
                bus.req[idx] = 1'b0;
                step();
                step();
                if (t < 3) bus.req[idx] = 1'b1;
            end
        end
        bus.req = '0;
        for (int t = 0; t < 6; t++) chk($sformatf("rr_order_%0d", t), 160'(order[t]), 160'(t % 3));
        repeat (6) step();

        // reset during READ; pointer left at 0 beforehand
        run_vec(vecs[0]);
        bus.req_x[6 +: 6] = 6'd3; bus.req_y[5 +: 5] = 5'd2; bus.req_code[4 +: 4] = 4'h2;
        bus.req[1] = 1'b1;
        step();
        chk("rd_busy", 160'(bus.busy), 160'(1));
        reset = 1'b1; bus.req[1] = 1'b0;
        step();
        chk("rd_rst_busy", 160'(bus.busy), 160'(0));
        chk("rd_rst_wren", 160'(bus.wren), 160'(0));
        chk("rd_rst_done", 160'(bus.done), 160'(0));
        reset = 1'b0;
        bus.req[0] = 1'b1; bus.req[1] = 1'b1;
        wait_done(idx, cyc);
        bus.req = '0;
        chk("rd_rst_first", 160'(idx), 160'(0));
        chk("rd_rst_lat", 160'(cyc), 160'(RD_LAT + 2));
        repeat (3) step();

        // reset during WRITE; write of that cycle must land in RAM
        preload(4, 160'h0);
        bus.req_x[12 +: 6] = 6'd4; bus.req_y[10 +: 5] = 5'd4; bus.req_code[8 +: 4] = 4'h9;
        bus.req[2] = 1'b1;
        step();
        step();
        chk("wr_wren", 160'(bus.wren), 160'(1));
        reset = 1'b1; bus.req[2] = 1'b0;
        step();
        chk("wr_rst_busy", 160'(bus.busy), 160'(0));
        chk("wr_rst_wren", 160'(bus.wren), 160'(0));
        chk("wr_rst_done", 160'(bus.done), 160'(0));
        exp_same = {{4{4'h0}}, 4'h9, {35{4'h0}}};
        chk("wr_rst_row", mem[4], exp_same);
        reset = 1'b0;
        bus.req[0] = 1'b1; bus.req[1] = 1'b1;
        wait_done(idx, cyc);
        bus.req = '0;
        chk("wr_rst_first", 160'(idx), 160'(0));
        repeat (3) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
